// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: in-order register-write queue with youngest-match forwarding.
// Optional WBUF_COALESCE_EN merges a push into the matching non-head tail entry.
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_reg,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       RegWrite,
    output logic [ADDR_W-1:0]          WriteRegister,
    output logic [DATA_W-1:0]          WriteData,
    input  logic [ADDR_W-1:0]          lookup_reg1,
    input  logic [ADDR_W-1:0]          lookup_reg2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [DATA_W-1:0]          fwd_data1,
    output logic [DATA_W-1:0]          fwd_data2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

    logic [ADDR_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] data [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head, tail, idx;
    logic              pop, push, merge, alloc;

    assign in_ready = count != CW'(DEPTH);
    assign pop      = count != '0;
    assign push     = in_valid && in_ready && in_reg != ZERO_REG;

`ifdef WBUF_COALESCE_EN
    logic [PW-1:0] last;
    assign last  = tail - 1'b1;
    assign merge = push && (count - CW'(pop)) >= CW'(2) && valid[last] && regs[last] == in_reg;
`else
    assign merge = 1'b0;
`endif

    assign alloc         = push && !merge;
    assign RegWrite      = pop;
    assign WriteRegister = pop ? regs[head] : '0;
    assign WriteData     = pop ? data[head] : '0;

    // Walk oldest to youngest so the last match seen is the one nearest the tail.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && valid[idx]) begin
                if (regs[idx] == lookup_reg1 && lookup_reg1 != ZERO_REG) begin
                    hit1      = 1'b1;
                    fwd_data1 = data[idx];
                end
                if (regs[idx] == lookup_reg2 && lookup_reg2 != ZERO_REG) begin
                    hit2      = 1'b1;
                    fwd_data2 = data[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            regs[tail] <= in_reg;
            data[tail] <= in_data;
        end
`ifdef WBUF_COALESCE_EN
        if (merge)
            data[last] <= in_data;
`endif
    end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb_regfile_write_buffer: table-driven directed checks plus a retire-order scoreboard.
module tb_regfile_write_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_reg = '0;
    logic [63:0] in_data = '0;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  lookup_reg1 = '0;
    logic [4:0]  lookup_reg2 = '0;
    logic        hit1, hit2;
    logic [63:0] fwd_data1, fwd_data2;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    regfile_write_buffer #(.DEPTH(4), .DATA_W(64), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
        .hit1(hit1), .hit2(hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ir;
        logic [63:0] id;
        logic [4:0]  l1, l2;
        logic        rw;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic        h1;
        logic [63:0] f1;
        logic        h2;
        logic [63:0] f2;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [4:0] ir, logic [63:0] id, logic [4:0] l1,
                                logic [4:0] l2, logic rw, logic [4:0] wr, logic [63:0] wd,
                                logic h1, logic [63:0] f1, logic h2, logic [63:0] f2,
                                logic [2:0] cnt);
        vec_t v;
        v.iv = iv; v.ir = ir; v.id = id; v.l1 = l1; v.l2 = l2;
        v.rw = rw; v.wr = wr; v.wd = wd; v.h1 = h1; v.f1 = f1;
        v.h2 = h2; v.f2 = f2; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Regfile-side capture: each cycle with RegWrite high retires exactly one entry.
    logic [68:0] got[$];
    always @(negedge clk)
        if (!reset && RegWrite === 1'b1)
            got.push_back({WriteRegister, WriteData});

    vec_t v[17];
    logic [68:0] exp_q[$];

    initial begin
        v[0]  = mk(0, 0, 64'h0, 3, 31,    0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0);
        v[1]  = mk(1, 3, 64'hAAAA, 3, 31, 0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0);
        v[2]  = mk(0, 0, 64'h0, 3, 3,     1, 3, 64'hAAAA, 1, 64'hAAAA, 1, 64'hAAAA, 1);
        v[3]  = mk(0, 0, 64'h0, 3, 3,     0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0);
        v[4]  = mk(1, 31, 64'hFFFF, 31, 31, 0, 0, 64'h0, 0, 64'h0,   0, 64'h0,   0);
        v[5]  = mk(0, 0, 64'h0, 31, 31,   0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0);
        v[6]  = mk(1, 7, 64'h11, 0, 7,    0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0);
        v[7]  = mk(1, 7, 64'h22, 0, 7,    1, 7, 64'h11,  0, 64'h0,   1, 64'h11,  1);
        v[8]  = mk(0, 0, 64'h0, 7, 7,     1, 7, 64'h22,  1, 64'h22,  1, 64'h22,  1);
        v[9]  = mk(0, 0, 64'h0, 7, 7,     0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0);
        v[10] = mk(1, 1, 64'h101, 1, 2,   0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0);
        v[11] = mk(1, 2, 64'h102, 1, 2,   1, 1, 64'h101, 1, 64'h101, 0, 64'h0,   1);
        v[12] = mk(1, 3, 64'h103, 2, 3,   1, 2, 64'h102, 1, 64'h102, 0, 64'h0,   1);
        v[13] = mk(1, 4, 64'h104, 3, 4,   1, 3, 64'h103, 1, 64'h103, 0, 64'h0,   1);
        v[14] = mk(1, 5, 64'h105, 4, 5,   1, 4, 64'h104, 1, 64'h104, 0, 64'h0,   1);
        v[15] = mk(0, 0, 64'h0, 5, 4,     1, 5, 64'h105, 1, 64'h105, 0, 64'h0,   1);
        v[16] = mk(0, 0, 64'h0, 5, 4,     0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("reset_state", 256'({RegWrite, WriteRegister, WriteData, count, in_ready, hit1, hit2}),
               256'({1'b0, 5'd0, 64'h0, 3'd0, 1'b1, 1'b0, 1'b0}));

        for (int i = 0; i < 17; i++) begin
            in_valid = v[i].iv; in_reg = v[i].ir; in_data = v[i].id;
            lookup_reg1 = v[i].l1; lookup_reg2 = v[i].l2;
            #1;
            chk($sformatf("vec%0d", i),
                256'({RegWrite, WriteRegister, WriteData, hit1, fwd_data1, hit2, fwd_data2, count, in_ready}),
                256'({v[i].rw, v[i].wr, v[i].wd, v[i].h1, v[i].f1, v[i].h2, v[i].f2, v[i].cnt, 1'b1}));
            @(posedge clk); #1;
        end

        for (int r = 10; r < 13; r++) begin
            in_valid = 1'b1; in_reg = 5'(r); in_data = 64'hA0 + 64'(r - 10);
            @(posedge clk); #1;
        end
        reset = 1'b1; in_reg = 5'd13; in_data = 64'hA3;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        #1 chk("after_reset", 256'({count, RegWrite, in_ready}), 256'({3'd0, 1'b0, 1'b1}));
        begin
            logic busy = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                busy = busy | RegWrite | (count != 3'd0);
            end
            chk("idle_after_reset", 256'(busy), 256'(1'b0));
        end

        exp_q = '{{5'd3, 64'hAAAA}, {5'd7, 64'h11}, {5'd7, 64'h22},
                  {5'd1, 64'h101}, {5'd2, 64'h102}, {5'd3, 64'h103}, {5'd4, 64'h104},
                  {5'd5, 64'h105}, {5'd10, 64'hA0}, {5'd11, 64'hA1}};
        chk("retire_count", 256'(got.size()), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("retire%0d", i), 256'(got[i]), 256'(exp_q[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
